wb_stage: RTL and testbench

Writeback stage of the LoongArch32 pipelined core. It holds a one-entry pipeline register between the memory stage and the register file, accepts one instruction per cycle over a valid/ready handshake, and aligns and extends load data. It selects the writeback value and drives the register file write port (`rf_we`, `rf_ra_d` as write address, `rf_wd`) on the cycle the instruction retires.

---
 rtl/wb_stage.sv | 126 ++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register from MEM to the register file,
// with load alignment/extension. Optional commit trace under WB_COMMIT_TRACE_EN.
module wb_stage #(
    parameter int COMMIT_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [31:0]             mem_pc,
    input  logic [31:0]             mem_inst,
    input  logic [31:0]             mem_alu_res,
    input  logic [31:0]             mem_ld_data,
    input  logic [1:0]              mem_wb_sel,
    input  logic [2:0]              mem_ld_type,
    input  logic                    mem_rf_we,
    input  logic [4:0]              mem_rf_wa,
    input  logic                    wb_stall,
    output logic                    rf_we,
    output logic [4:0]              rf_ra_d,
    output logic [31:0]             rf_wd,
    output logic                    wb_busy,
    output logic [4:0]              wb_busy_wa
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic                    commit_valid,
    output logic [31:0]             commit_pc,
    output logic [31:0]             commit_inst,
    output logic [COMMIT_CNT_W-1:0] commit_cnt
`endif
);

    if (COMMIT_CNT_W < 1) begin : g_cnt_w_check
        $error("COMMIT_CNT_W must be at least 1");
    end

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_wd;
    logic        r_we;
    logic [4:0]  r_wa;

    logic        w_accept;
    logic        w_retire;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_val;
    logic [31:0] w_wd;

    assign mem_ready = !r_valid || !wb_stall;
    assign w_accept  = mem_valid && mem_ready;
    assign w_retire  = r_valid && !wb_stall;

    // Load alignment happens before the register so rf_* see only registered state.
    always_comb begin
        w_byte = mem_ld_data[7:0];
        case (mem_alu_res[1:0])
            2'd1:    w_byte = mem_ld_data[15:8];
            2'd2:    w_byte = mem_ld_data[23:16];
            2'd3:    w_byte = mem_ld_data[31:24];
            default: w_byte = mem_ld_data[7:0];
        endcase
        w_half = mem_alu_res[1] ? mem_ld_data[31:16] : mem_ld_data[15:0];

        case (mem_ld_type)
            3'b000:  w_ld_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_val = {24'd0, w_byte};
            3'b101:  w_ld_val = {16'd0, w_half};
            default: w_ld_val = mem_ld_data;
        endcase

        case (mem_wb_sel)
            2'b00:   w_wd = mem_alu_res;
            2'b01:   w_wd = w_ld_val;
            2'b10:   w_wd = mem_pc + 32'd4;
            default: w_wd = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'd0;
            r_inst  <= 32'd0;
            r_wd    <= 32'd0;
            r_we    <= 1'b0;
            r_wa    <= 5'd0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= mem_pc;
            r_inst  <= mem_inst;
            r_wd    <= w_wd;
            r_we    <= mem_rf_we;
            r_wa    <= mem_rf_wa;
        end else if (w_retire) begin
            r_valid <= 1'b0;
        end
    end

    // r0 writes still retire but never reach the register file.
    assign rf_we      = w_retire && r_we && (r_wa != 5'd0);
    assign rf_ra_d    = r_wa;
    assign rf_wd      = r_wd;
    assign wb_busy    = r_valid;
    assign wb_busy_wa = r_we ? r_wa : 5'd0;

`ifdef WB_COMMIT_TRACE_EN
    logic [COMMIT_CNT_W-1:0] r_commit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_cnt <= '0;
        end else if (w_retire) begin
            r_commit_cnt <= r_commit_cnt + COMMIT_CNT_W'(1);
        end
    end

    assign commit_valid = w_retire;
    assign commit_pc    = r_pc;
    assign commit_inst  = r_inst;
    assign commit_cnt   = r_commit_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a behavioural model of the writeback entry.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_ld_data;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_ld_type;
    logic        mem_rf_we;
    logic [4:0]  mem_rf_wa;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_ra_d;
    logic [31:0] rf_wd;
    logic        wb_busy;
    logic [4:0]  wb_busy_wa;
`ifdef WB_COMMIT_TRACE_EN
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [31:0] commit_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: at most one held instruction plus the retire count.
    bit          m_valid;
    logic [31:0] m_pc, m_inst, m_wd;
    bit          m_we;
    logic [4:0]  m_wa;
    int unsigned m_cnt;
    int          r3_writes;

    wb_stage #(.COMMIT_CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_pc      (mem_pc),
        .mem_inst    (mem_inst),
        .mem_alu_res (mem_alu_res),
        .mem_ld_data (mem_ld_data),
        .mem_wb_sel  (mem_wb_sel),
        .mem_ld_type (mem_ld_type),
        .mem_rf_we   (mem_rf_we),
        .mem_rf_wa   (mem_rf_wa),
        .wb_stall    (wb_stall),
        .rf_we       (rf_we),
        .rf_ra_d     (rf_ra_d),
        .rf_wd       (rf_wd),
        .wb_busy     (wb_busy),
        .wb_busy_wa  (wb_busy_wa)
`ifdef WB_COMMIT_TRACE_EN
        ,
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .commit_cnt  (commit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wd(input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [31:0] ld, input logic [1:0] sel,
                                             input logic [2:0] t);
        int unsigned b, h, a;
        a = alu;
        b = (ld >> (8 * (a % 4))) % 256;
        h = (ld >> (16 * ((a / 2) % 2))) % 65536;
        if (sel == 2'b00) return alu;
        if (sel == 2'b10) return pc + 32'd4;
        if (sel == 2'b11) return 32'd0;
        case (t)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return ld;
        endcase
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_pc = 0; m_inst = 0; m_wd = 0; m_we = 0; m_wa = 0; m_cnt = 0;
    endfunction

    task automatic check_outputs();
        bit ret;
        ret = m_valid && !wb_stall;
        check("mem_ready", mem_ready, !m_valid || !wb_stall);
        check("rf_we", rf_we, ret && m_we && (m_wa != 0));
        check("rf_ra_d", rf_ra_d, m_wa);
        check("rf_wd", rf_wd, m_wd);
        check("wb_busy", wb_busy, m_valid);
        check("wb_busy_wa", wb_busy_wa, m_we ? m_wa : 5'd0);
`ifdef WB_COMMIT_TRACE_EN
        check("commit_valid", commit_valid, ret);
        if (ret) begin
            check("commit_pc", commit_pc, m_pc);
            check("commit_inst", commit_inst, m_inst);
        end
        check("commit_cnt", commit_cnt, m_cnt);
`endif
        if (rf_we && rf_ra_d == 5'd3) r3_writes++;
    endtask

    // One clock cycle with the currently driven inputs: check mid-cycle, then advance the model.
    task automatic tick();
        bit acc, ret;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = mem_valid && (!m_valid || !wb_stall);
            ret = m_valid && !wb_stall;
            if (ret) m_cnt++;
            if (acc) begin
                m_valid = 1;
                m_pc    = mem_pc;
                m_inst  = mem_inst;
                m_wd    = model_wd(mem_pc, mem_alu_res, mem_ld_data, mem_wb_sel, mem_ld_type);
                m_we    = mem_rf_we;
                m_wa    = mem_rf_wa;
            end else if (ret) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [1:0] sel, input logic [2:0] t,
                         input logic we, input logic [4:0] wa, input logic stall);
        mem_valid = v; mem_pc = pc; mem_inst = pc ^ 32'h1357_9BDF; mem_alu_res = alu;
        mem_ld_data = ld; mem_wb_sel = sel; mem_ld_type = t; mem_rf_we = we;
        mem_rf_wa = wa; wb_stall = stall;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", mem_ready, 1'b1);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_ra_d", rf_ra_d, 5'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_busy", wb_busy, 1'b0);
        check("rst_busy_wa", wb_busy_wa, 5'd0);
        $display("reset state checked");

        // Load alignment cases
        drive(1, 32'h100, 32'h1003, 32'h80FF_1234, 2'b01, 3'b000, 1, 5'd5, 0); tick(); idle();
        check("ldb_wd", rf_wd, 32'hFFFF_FF80); check("ldb_we", rf_we, 1'b1);
        $display("LD.B  wd=%h we=%b", rf_wd, rf_we);
        drive(1, 32'h104, 32'h1003, 32'h80FF_1234, 2'b01, 3'b100, 1, 5'd5, 0); tick(); idle();
        check("ldbu_wd", rf_wd, 32'h0000_0080);
        $display("LD.BU wd=%h", rf_wd);
        drive(1, 32'h108, 32'h1002, 32'h8001_7FFF, 2'b01, 3'b001, 1, 5'd6, 0); tick(); idle();
        check("ldh_wd", rf_wd, 32'hFFFF_8001);
        $display("LD.H  wd=%h", rf_wd);
        drive(1, 32'h10C, 32'h1000, 32'h8001_7FFF, 2'b01, 3'b101, 1, 5'd6, 0); tick(); idle();
        check("ldhu_wd", rf_wd, 32'h0000_7FFF);
        $display("LD.HU wd=%h", rf_wd);
        drive(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10, 3'b010, 1, 5'd1, 0); tick(); idle();
        check("pc4_wd", rf_wd, 32'h0); check("pc4_ra", rf_ra_d, 5'd1);
        $display("PC+4  wd=%h ra=%0d", rf_wd, rf_ra_d);

        // r0 write
        drive(1, 32'h200, 32'hDEAD_BEEF, 0, 2'b00, 3'b010, 1, 5'd0, 0); tick(); idle();
        check("r0_we", rf_we, 1'b0); check("r0_busy_wa", wb_busy_wa, 5'd0);
`ifdef WB_COMMIT_TRACE_EN
        check("r0_commit", commit_valid, 1'b1);
`endif
        $display("r0    we=%b busy_wa=%0d", rf_we, wb_busy_wa);
        tick();

        // Stall scenario after a fresh reset
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); rst = 1'b0;
        r3_writes = 0;
        drive(1, 32'h300, 32'h11, 0, 2'b00, 3'b010, 1, 5'd3, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h304, 32'h22, 0, 2'b00, 3'b010, 1, 5'd4, 1);
            #1;
            check("stall_ready", mem_ready, 1'b0); check("stall_we", rf_we, 1'b0);
            tick();
        end
        drive(1, 32'h304, 32'h22, 0, 2'b00, 3'b010, 1, 5'd4, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("r4_wa", rf_ra_d, 5'd4); check("r4_wd", rf_wd, 32'h22); check("r4_we", rf_we, 1'b1);
        tick(); tick();
        check("r3_once", r3_writes, 1);
`ifdef WB_COMMIT_TRACE_EN
        check("stall_cnt", commit_cnt, 32'd2);
`endif
        $display("stall r3_writes=%0d", r3_writes);

        // Reset while an entry is held
        drive(1, 32'h400, 32'h55, 0, 2'b00, 3'b010, 1, 5'd7, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("mid_rst_busy", wb_busy, 1'b0); check("mid_rst_wd", rf_wd, 32'd0);
        check("mid_rst_we", rf_we, 1'b0);
`ifdef WB_COMMIT_TRACE_EN
        check("mid_rst_cnt", commit_cnt, 32'd0);
`endif
        $display("mid-op reset busy=%b wd=%h", wb_busy, rf_wd);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        $display("random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
